// File: rtl/mem_arbiter_responder.sv
// Memory-side responder: arbitrates dcache/icache requests onto one shared
// variable-latency RAM port, one access in flight, with per-requester counters.
module mem_arbiter_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FAIR   = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic [31:0]       d_acc_cnt,
    output logic [31:0]       i_acc_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] store_reg, store_next;
    logic              write_reg, write_next;
    logic              last_i_reg, last_i_next;
    logic [31:0]       d_cnt_reg, i_cnt_reg;

    logic d_req, i_req, grant_d, d_done, i_done;

    assign d_req   = dREN | dWEN;
    assign i_req   = iREN;
    // On a tie the fair variant hands the grant to whoever did not get the last one.
    assign grant_d = d_req && (!i_req || (FAIR == 0) || last_i_reg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            store_reg  <= '0;
            write_reg  <= 1'b0;
            last_i_reg <= 1'b1;
            d_cnt_reg  <= 32'd0;
            i_cnt_reg  <= 32'd0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            store_reg  <= store_next;
            write_reg  <= write_next;
            last_i_reg <= last_i_next;
            if (d_done) d_cnt_reg <= d_cnt_reg + 32'd1;
            if (i_done) i_cnt_reg <= i_cnt_reg + 32'd1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        store_next  = store_reg;
        write_next  = write_reg;
        last_i_next = last_i_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next  = D_ACC;
                    addr_next   = daddr;
                    store_next  = dstore;
                    write_next  = dWEN;
                    last_i_next = 1'b0;
                end else if (i_req) begin
                    state_next  = I_ACC;
                    addr_next   = iaddr;
                    store_next  = '0;
                    write_next  = 1'b0;
                    last_i_next = 1'b1;
                end
            end
            D_ACC: begin
                if (ram_ready)   state_next = IDLE;
                else if (!d_req) state_next = DRAIN;
            end
            I_ACC: begin
                if (ram_ready)   state_next = IDLE;
                else if (!i_req) state_next = DRAIN;
            end
            DRAIN: begin
                // Strobes stay up until the RAM finishes the abandoned access.
                if (ram_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        d_done    = (state_reg == D_ACC) && ram_ready && d_req;
        i_done    = (state_reg == I_ACC) && ram_ready && i_req;
        dwait     = !d_done;
        iwait     = !i_done;
        dload     = (d_done && !write_reg) ? ram_load : '0;
        iload     = i_done ? ram_load : '0;
        ram_ren   = (state_reg != IDLE) && !write_reg;
        ram_wen   = (state_reg != IDLE) && write_reg;
        ram_addr  = addr_reg;
        ram_store = store_reg;
    end

    assign d_acc_cnt = d_cnt_reg;
    assign i_acc_cnt = i_cnt_reg;

endmodule

// File: doc/mem_arbiter_responder.md
Name: mem_arbiter_responder

Overview:
- Memory-side responder for the cache control interface.
- Serves read/write requests from the dcache and read requests from the icache over one shared single-port RAM with variable latency.
- One access is in flight at a time. Each cache sees a standard handshake: wait held high until its access completes, then one cycle with wait low and load data valid.
- Counts completed accesses per requester for the performance registers.

Parameters:
- ADDR_W, 32, address width for daddr, iaddr and ram_addr.
- DATA_W, 32, data width for load/store buses.
- FAIR, 0: 0 = dcache always wins simultaneous requests; 1 = round-robin on ties, so the requester not granted last time wins.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache word address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  low for exactly the completion cycle of a dcache access.
- dload  out  DATA_W  dcache read data, valid when dwait=0 and the op was a read.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache word address.
- iwait  out  1  low for exactly the completion cycle of an icache access.
- iload  out  DATA_W  icache read data, valid when iwait=0.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data, valid with ram_ready.
- ram_ready  in  1  one-cycle pulse: RAM access done.
- d_acc_cnt  out  32  completed dcache accesses, wrapping.
- i_acc_cnt  out  32  completed icache accesses, wrapping.

Behaviour:
- Reset (RST sampled high at the CLK edge): state=IDLE, dwait=iwait=1, ram_ren=ram_wen=0, ram_addr=ram_store=0, dload=iload=0, counters=0, last_grant=I (so the first tie goes to D under FAIR=1).
- Reset mid-access: the next edge goes to IDLE, strobes drop, and a pending ram_ready is ignored. The RAM is required to tolerate strobe removal.
- States:
  - IDLE: no strobes.
  - D_ACC: request latched at grant from dcache.
  - I_ACC: request latched at grant from icache.
  - DRAIN: waiting out an abandoned access.
- IDLE arbitration, evaluated each cycle:
  - d_req = dREN|dWEN; i_req = iREN.
  - Only one requesting: grant it.
  - Both, FAIR=0: grant D.
  - Both, FAIR=1: grant the one not equal to last_grant.
  - On grant, register the address, store data and op (write if dWEN, else read; dREN&dWEN is treated as a write) and move to D_ACC or I_ACC at the next edge. Update last_grant.
- D_ACC / I_ACC:
  - Drive ram_ren or ram_wen, ram_addr and ram_store from the latched registers; all are stable until completion.
  - On ram_ready=1 with the requester still asserting: the matching wait goes low in the same cycle (combinational from ram_ready).
  - dload/iload = ram_load in that cycle; the load output is 0 for writes.
  - The counter increments at the edge. Next state is IDLE.
- Minimum latency: grant cycle + 1 RAM cycle. One idle bubble between consecutive accesses.
- Requester drops its request while in D_ACC/I_ACC:
  - Go to DRAIN and keep the strobe and address held.
  - Wait stays high, the response is discarded, no count.
  - Return to IDLE on ram_ready.
- Address change while granted is not tracked; the latched address is used. The cache re-requests after completion.
- Wait outputs are high in every cycle other than a completion cycle, including while the requester is idle.
- Counters increment only on completion cycles and wrap from FFFFFFFF to 0.
- No simultaneous completion: dwait and iwait are never both low.

Test Plan:
- dREN=1, daddr=0x100, ram_ready pulses 3 cycles after strobe, ram_load=0xDEADBEEF -> ram_ren/ram_addr=0x100 held 3 cycles, dwait=0 with dload=0xDEADBEEF for one cycle, d_acc_cnt=1, back to IDLE.
- dWEN=1, daddr=0x3100, dstore=0x12 -> ram_wen=1, ram_store=0x12; dwait low one cycle on ready; dload=0.
- dREN and iREN both held, FAIR=0, 4 accesses -> 4 dcache grants, iwait stays 1. FAIR=1 -> grants alternate D,I,D,I starting with D.
- dcache drops dREN mid-access -> DRAIN, strobe held until ready, dwait stays 1, d_acc_cnt unchanged, then an icache request is served.
- RST pulsed during D_ACC -> next edge: strobes 0, counters 0, dwait=iwait=1. A later ram_ready produces no completion.
- d_acc_cnt preloaded via force to 0xFFFFFFFF, one dcache completion -> 0x00000000.
